// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - memory bus arbiter between CPU, UART loader and UART dumper
module mem_bus_arbiter #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] cpu_addr_data,
    input  logic       cpu_read_write,
    input  logic       cpu_write_commit,
    input  logic       ld_req,
    input  logic [9:0] ld_addr_data,
    input  logic       ld_read_write,
    input  logic       ld_write_commit,
    input  logic       dmp_req,
    input  logic [9:0] dmp_addr_data,
    input  logic       dmp_read_write,
    input  logic       dmp_write_commit,
    output logic       ld_gnt,
    output logic       dmp_gnt,
    output logic [9:0] mem_addr_data,
    output logic       mem_read_write,
    output logic       mem_write_commit,
    output logic       cpu_hold,
    output logic       cpu_halted,
    output logic       proto_err,
    output logic [1:0] owner
);

    localparam int CW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Encoding matches the owner code so owner is the state register itself.
    typedef enum logic [1:0] {
        CPU_RUN  = 2'd0,
        UART_LD  = 2'd1,
        UART_DMP = 2'd2,
        GUARD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          addr_pend_q, addr_pend_d;
    logic          halted_q, halted_d;
    logic          perr_q, perr_d;
    logic          halt_seen;
    logic          perr_set;
    logic          cpu_addr_phase;

    assign cpu_addr_phase = !cpu_read_write && !cpu_write_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GUARD;
            cnt_q       <= CNT_LOAD;
            addr_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_pend_q <= addr_pend_d;
            halted_q    <= halted_d;
            perr_q      <= perr_d;
        end
    end

    // Bus mux; every non-forwarding case falls back to the idle read pattern.
    always_comb begin
        mem_addr_data    = 10'd0;
        mem_read_write   = 1'b1;
        mem_write_commit = 1'b0;
        halt_seen        = 1'b0;
        case (state_q)
            CPU_RUN: begin
                if (cpu_read_write && cpu_write_commit) begin
                    halt_seen = 1'b1;
                end else begin
                    mem_addr_data    = cpu_addr_data;
                    mem_read_write   = cpu_read_write;
                    mem_write_commit = cpu_write_commit;
                end
            end
            UART_LD: begin
                if (ld_req || !addr_pend_q) begin
                    mem_addr_data    = ld_addr_data;
                    mem_read_write   = ld_read_write;
                    mem_write_commit = ld_write_commit;
                end
            end
            UART_DMP: begin
                if (dmp_req || !addr_pend_q) begin
                    mem_addr_data    = dmp_addr_data;
                    mem_read_write   = dmp_read_write;
                    mem_write_commit = dmp_write_commit;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        perr_set = 1'b0;
        case (state_q)
            CPU_RUN: begin
                if ((ld_req || dmp_req) && !cpu_addr_phase) begin
                    state_d = ld_req ? UART_LD : UART_DMP;
                end
            end
            UART_LD: begin
                if (!ld_req) begin
                    // An orphaned address phase costs one idle granted cycle.
                    if (addr_pend_q) begin
                        perr_set = 1'b1;
                    end else if (dmp_req) begin
                        state_d = UART_DMP;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            UART_DMP: begin
                if (!dmp_req) begin
                    if (addr_pend_q) begin
                        perr_set = 1'b1;
                    end else if (ld_req) begin
                        state_d = UART_LD;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (ld_req) begin
                    state_d = UART_LD;
                end else if (dmp_req) begin
                    state_d = UART_DMP;
                end else if (cnt_q == '0) begin
                    state_d = CPU_RUN;
                end
            end
        endcase
    end

    always_comb begin
        addr_pend_d = !mem_read_write && !mem_write_commit;
        perr_d      = perr_q || perr_set;
        halted_d    = halted_q;
        if (state_q == CPU_RUN && state_d != CPU_RUN) begin
            halted_d = 1'b0;
        end else if (halt_seen) begin
            halted_d = 1'b1;
        end
    end

    assign owner      = state_q;
    assign ld_gnt     = (state_q == UART_LD);
    assign dmp_gnt    = (state_q == UART_DMP);
    assign cpu_hold   = (state_q != CPU_RUN);
    assign cpu_halted = halted_q;
    assign proto_err  = perr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] cpu_addr_data = 10'd0;
    logic       cpu_read_write = 1'b1;
    logic       cpu_write_commit = 1'b0;
    logic       ld_req = 1'b0;
    logic [9:0] ld_addr_data = 10'd0;
    logic       ld_read_write = 1'b1;
    logic       ld_write_commit = 1'b0;
    logic       dmp_req = 1'b0;
    logic [9:0] dmp_addr_data = 10'd0;
    logic       dmp_read_write = 1'b1;
    logic       dmp_write_commit = 1'b0;
    logic       ld_gnt, dmp_gnt, cpu_hold, cpu_halted, proto_err;
    logic [9:0] mem_addr_data;
    logic       mem_read_write, mem_write_commit;
    logic [1:0] owner;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    mem_bus_arbiter #(.GUARD_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr_data(cpu_addr_data), .cpu_read_write(cpu_read_write),
        .cpu_write_commit(cpu_write_commit),
        .ld_req(ld_req), .ld_addr_data(ld_addr_data), .ld_read_write(ld_read_write),
        .ld_write_commit(ld_write_commit),
        .dmp_req(dmp_req), .dmp_addr_data(dmp_addr_data), .dmp_read_write(dmp_read_write),
        .dmp_write_commit(dmp_write_commit),
        .ld_gnt(ld_gnt), .dmp_gnt(dmp_gnt),
        .mem_addr_data(mem_addr_data), .mem_read_write(mem_read_write),
        .mem_write_commit(mem_write_commit),
        .cpu_hold(cpu_hold), .cpu_halted(cpu_halted), .proto_err(proto_err),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, guard cycles left, last bus was an address phase.
    int m_owner = 3;
    int m_cnt = G;
    bit m_pend = 1'b0;
    bit m_halt = 1'b0;
    bit m_perr = 1'b0;

    function automatic logic [11:0] model_bus();
        logic [11:0] idle;
        idle = {10'd0, 1'b1, 1'b0};
        case (m_owner)
            0: return (cpu_read_write && cpu_write_commit) ? idle
                       : {cpu_addr_data, cpu_read_write, cpu_write_commit};
            1: return (!ld_req && m_pend) ? idle
                       : {ld_addr_data, ld_read_write, ld_write_commit};
            2: return (!dmp_req && m_pend) ? idle
                       : {dmp_addr_data, dmp_read_write, dmp_write_commit};
            default: return idle;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [11:0] b;
        int nxt;
        int cnt;
        bit halt;
        bit perr;
        if (!rst_n) begin
            m_owner <= 3;
            m_cnt   <= G;
            m_pend  <= 1'b0;
            m_halt  <= 1'b0;
            m_perr  <= 1'b0;
        end else begin
            b    = model_bus();
            nxt  = m_owner;
            cnt  = m_cnt;
            halt = m_halt;
            perr = m_perr;
            if (m_owner == 0) begin
                if (cpu_read_write && cpu_write_commit) halt = 1'b1;
                if ((ld_req || dmp_req) && (cpu_read_write || cpu_write_commit))
                    nxt = ld_req ? 1 : 2;
            end else if (m_owner == 1 && !ld_req) begin
                if (m_pend) perr = 1'b1;
                else nxt = dmp_req ? 2 : 3;
            end else if (m_owner == 2 && !dmp_req) begin
                if (m_pend) perr = 1'b1;
                else nxt = ld_req ? 1 : 3;
            end else if (m_owner == 3) begin
                if (ld_req) nxt = 1;
                else if (dmp_req) nxt = 2;
                else if (cnt == 0) nxt = 0;
                if (cnt > 0) cnt = cnt - 1;
            end
            if (nxt == 3 && m_owner != 3) cnt = G;
            if (m_owner == 0 && nxt != 0) halt = 1'b0;
            m_owner <= nxt;
            m_cnt   <= cnt;
            m_halt  <= halt;
            m_perr  <= perr;
            m_pend  <= (b[1:0] == 2'b00);
        end
    end

    always @(negedge clk) begin
        logic [18:0] act;
        logic [18:0] exp;
        if (cmp_en) begin
            act = {owner, ld_gnt, dmp_gnt, cpu_hold, cpu_halted, proto_err,
                   mem_addr_data, mem_read_write, mem_write_commit};
            exp = {2'(m_owner), m_owner == 1, m_owner == 2, m_owner != 0, m_halt, m_perr,
                   model_bus()};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %05h expected %05h", $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_owner(input logic [1:0] target, input int max_cycles);
        int i;
        for (i = 0; i < max_cycles && owner !== target; i++) step();
        check("wait_owner_bound", owner, target);
    endtask

    task automatic set_cpu(input logic [9:0] a, input logic rw, input logic c);
        cpu_addr_data = a; cpu_read_write = rw; cpu_write_commit = c;
    endtask

    task automatic set_ld(input logic [9:0] a, input logic rw, input logic c);
        ld_addr_data = a; ld_read_write = rw; ld_write_commit = c;
    endtask

    task automatic set_dmp(input logic [9:0] a, input logic rw, input logic c);
        dmp_addr_data = a; dmp_read_write = rw; dmp_write_commit = c;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset_owner", owner, 2'd3);
        check("reset_hold", cpu_hold, 1'b1);
        check("reset_bus", {mem_addr_data, mem_read_write, mem_write_commit}, 12'b0000000000_10);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) step();
        check("guard_edge4_hold", cpu_hold, 1'b1);
        check("guard_edge4_owner", owner, 2'd3);
        step();
        check("guard_edge5_hold", cpu_hold, 1'b0);
        check("guard_edge5_owner", owner, 2'd0);

        // CPU write in progress when the loader asks for the bus
        set_cpu(10'h155, 1'b0, 1'b0); ld_req = 1'b1;
        #1 check("cpu_addr_fwd", mem_addr_data, 10'h155);
        step();
        set_cpu(10'h2AA, 1'b0, 1'b1);
        #1 check("cpu_data_fwd", {mem_addr_data, mem_write_commit, owner}, {10'h2AA, 1'b1, 2'd0});
        step();
        set_cpu(10'h000, 1'b1, 1'b0);
        check("ld_gnt_n2", {ld_gnt, cpu_hold, owner}, {1'b1, 1'b1, 2'd1});
        set_ld(10'h011, 1'b0, 1'b0); step();
        set_ld(10'h022, 1'b0, 1'b1); step();
        set_ld(10'h033, 1'b1, 1'b0);
        #1 check("ld_read_fwd", {mem_addr_data, mem_read_write}, {10'h033, 1'b1});
        step();
        ld_req = 1'b0; set_ld(10'h000, 1'b1, 1'b0);
        check("ld_drop_still_owner", owner, 2'd1);
        step();
        check("ld_exit_guard", owner, 2'd3);
        step(); step();
        dmp_req = 1'b1; set_dmp(10'h100, 1'b1, 1'b0);
        step();
        check("guard_preempt_dmp", dmp_gnt, 1'b1);
        dmp_req = 1'b0;
        step();
        wait_owner(2'd0, 10);

        // Halt pattern
        set_cpu(10'h3FF, 1'b1, 1'b1);
        #1 check("halt_idle_bus", {mem_addr_data, mem_read_write, mem_write_commit}, 12'b0000000000_10);
        step();
        set_cpu(10'h000, 1'b1, 1'b0);
        check("halted_set", cpu_halted, 1'b1);
        dmp_req = 1'b1;
        step();
        check("halted_clear", {owner, cpu_halted}, {2'd2, 1'b0});
        dmp_req = 1'b0;
        step();
        wait_owner(2'd0, 10);

        // Simultaneous requests: loader first, direct handoff
        ld_req = 1'b1; dmp_req = 1'b1;
        step();
        check("both_req_ld_first", owner, 2'd1);
        ld_req = 1'b0;
        step();
        check("handoff_dmp", {owner, cpu_hold}, {2'd2, 1'b1});
        ld_req = 1'b1; dmp_req = 1'b0;
        step();
        check("handoff_ld", owner, 2'd1);

        // Loader abandons a write after its address phase
        set_ld(10'h0F0, 1'b0, 1'b0);
        step();
        ld_req = 1'b0; set_ld(10'h3C3, 1'b0, 1'b1);
        #1 check("drop_idle_bus", {ld_gnt, mem_addr_data, mem_read_write, mem_write_commit},
                 {1'b1, 12'b0000000000_10});
        step();
        set_ld(10'h000, 1'b1, 1'b0);
        check("drop_extra_gnt", {proto_err, ld_gnt}, 2'b11);
        step();
        check("drop_to_guard", {owner, proto_err}, {2'd3, 1'b1});

        // Asynchronous reset in the middle of a loader write
        ld_req = 1'b1;
        step();
        check("guard_preempt_ld", owner, 2'd1);
        set_ld(10'h155, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {ld_gnt, owner, proto_err, mem_addr_data, mem_read_write, mem_write_commit},
                 {1'b0, 2'd3, 1'b0, 12'b0000000000_10});
        ld_req = 1'b0; set_ld(10'h2AA, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("no_data_after_reset", mem_write_commit, 1'b0);
        wait_owner(2'd0, 10);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
